up_down_counter_param: RTL and testbench

- Parametrised successor to the fixed 2-bit DFF up/down counter.
- Generalised width and modulus, with clock enable, synchronous parallel load, and wrap or saturate mode.
- Provides terminal-count and wrap-event outputs for cascading into timers and address generators.
- Single clock domain; its state is held in registers updated on the rising clock edge.

---
 rtl/up_down_counter_param.sv | 110 +++++++++++
 tb/tb_up_down_counter_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_param.sv
// up_down_counter_param
// Parametrised up/down counter with clock enable, synchronous parallel load,
// and wrap-or-saturate boundary handling. tc is a combinational terminal
// count in the current direction; wrap is a registered one-cycle pulse for
// each boundary event, suitable for cascading into timers and address
// generators.
//
// Optional feature: define UDC_STICKY_FLAG_EN to add the clr_flag input and
// a registered sticky flag output that latches any wrap event until cleared.
`timescale 1ns/1ps

module up_down_counter_param #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
  parameter int              SATURATE  = 0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDC_STICKY_FLAG_EN
  input  logic             clr_flag,
  output logic             flag,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Elaboration-time legality checks; an illegal configuration stops the build.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "up_down_counter_param: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "up_down_counter_param: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end
  if (RESET_VAL > MODULUS - 64'd1) begin : g_bad_reset_val
    $fatal(1, "up_down_counter_param: RESET_VAL=%0d exceeds MODULUS-1", RESET_VAL);
  end

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX};
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic [WIDTH:0]   q_inc;
  logic [WIDTH:0]   load_ext;
  logic             at_zero;

  // The increment is done one bit wider so a step past MAX is visible even
  // when MODULUS == 2**WIDTH and the WIDTH-bit sum would silently roll over.
  assign q_inc    = {1'b0, q} + (WIDTH+1)'(1);
  assign load_ext = {1'b0, load_val};
  assign at_zero  = (q == '0);

  assign tc = up_down ? (q == MAX) : at_zero;

  // Next-count and boundary-event decode; priority is load, then enable.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = (load_ext > MAX_EXT) ? MAX : load_val;
    end else if (en) begin
      if (up_down) begin
        if (q_inc > MAX_EXT) begin
          wrap_next = 1'b1;
          q_next    = SAT ? MAX : '0;
        end else begin
          q_next = q_inc[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          wrap_next = 1'b1;
          q_next    = SAT ? '0 : MAX;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

`ifdef UDC_STICKY_FLAG_EN
  // Sticky boundary flag; a new event on the clearing edge keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag <= 1'b0;
    end else begin
      flag <= wrap_next | (flag & ~clr_flag);
    end
  end
`endif

endmodule

// File: tb/tb_up_down_counter_param.sv
// Testbench for up_down_counter_param: three instances with different
// configurations share one stimulus stream and are checked against an
// integer-arithmetic reference model.
`timescale 1ns/1ps

module tb_up_down_counter_param;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, up_down, load;
  logic [1:0] lv_a;
  logic [2:0] lv_b;
  logic [3:0] lv_c;
  logic [1:0] q_a;
  logic [2:0] q_b;
  logic [3:0] q_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;
`ifdef UDC_STICKY_FLAG_EN
  logic       clr_flag;
  logic       flag_a, flag_b, flag_c;
`endif

  // a: WIDTH=2 wrapping; b: WIDTH=3 MODULUS=6 saturating; c: WIDTH=4, RESET_VAL=3
  up_down_counter_param #(.WIDTH(2), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(lv_a),
`ifdef UDC_STICKY_FLAG_EN
    .clr_flag(clr_flag), .flag(flag_a),
`endif
    .q(q_a), .tc(tc_a), .wrap(wrap_a));

  up_down_counter_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(lv_b),
`ifdef UDC_STICKY_FLAG_EN
    .clr_flag(clr_flag), .flag(flag_b),
`endif
    .q(q_b), .tc(tc_b), .wrap(wrap_b));

  up_down_counter_param #(.WIDTH(4), .RESET_VAL(3)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(lv_c),
`ifdef UDC_STICKY_FLAG_EN
    .clr_flag(clr_flag), .flag(flag_c),
`endif
    .q(q_c), .tc(tc_c), .wrap(wrap_c));

  logic [31:0] oq[NDUT];
  logic        ow[NDUT];
  logic        otc[NDUT];
  assign oq[0] = 32'(q_a);  assign oq[1] = 32'(q_b);  assign oq[2] = 32'(q_c);
  assign ow[0] = wrap_a;    assign ow[1] = wrap_b;    assign ow[2] = wrap_c;
  assign otc[0] = tc_a;     assign otc[1] = tc_b;     assign otc[2] = tc_c;
`ifdef UDC_STICKY_FLAG_EN
  logic        ofl[NDUT];
  assign ofl[0] = flag_a;   assign ofl[1] = flag_b;   assign ofl[2] = flag_c;
`endif

  // Reference model: per-instance count range and boundary policy.
  int  m_max[NDUT];
  int  m_bits[NDUT];
  int  m_rst[NDUT];
  bit  m_sat[NDUT];
  int  mq[NDUT];
  bit  mw[NDUT];
  bit  mf[NDUT];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      int exp_tc;
      exp_tc = up_down ? int'(mq[i] == m_max[i]) : int'(mq[i] == 0);
      chk({tag, "_q"}, i, oq[i], 32'(mq[i]));
      chk({tag, "_wrap"}, i, 32'(ow[i]), 32'(mw[i]));
      chk({tag, "_tc"}, i, 32'(otc[i]), 32'(exp_tc));
`ifdef UDC_STICKY_FLAG_EN
      chk({tag, "_flag"}, i, 32'(ofl[i]), 32'(mf[i]));
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      mq[i] = m_rst[i];
      mw[i] = 1'b0;
      mf[i] = 1'b0;
    end
  endtask

  // One rising edge of the specification's priority rules: load > en > hold.
  task automatic model_edge(input bit ld, input int lv, input bit e,
                            input bit ud, input bit clr);
    for (int i = 0; i < NDUT; i++) begin
      int v, nq;
      bit nw;
      v  = lv % (1 << m_bits[i]);
      nq = mq[i];
      nw = 1'b0;
      if (ld) begin
        nq = (v > m_max[i]) ? m_max[i] : v;
      end else if (e && ud) begin
        if (mq[i] == m_max[i]) begin
          nw = 1'b1;
          nq = m_sat[i] ? m_max[i] : 0;
        end else begin
          nq = mq[i] + 1;
        end
      end else if (e) begin
        if (mq[i] == 0) begin
          nw = 1'b1;
          nq = m_sat[i] ? 0 : m_max[i];
        end else begin
          nq = mq[i] - 1;
        end
      end
      mf[i] = nw | (mf[i] & ~clr);
      mq[i] = nq;
      mw[i] = nw;
    end
  endtask

  task automatic drive(input bit e, input bit ud, input bit ld, input int lv,
                       input bit clr);
    logic [31:0] lvv;
    lvv     = 32'(lv);
    en      = e;
    up_down = ud;
    load    = ld;
    lv_a    = lvv[1:0];
    lv_b    = lvv[2:0];
    lv_c    = lvv[3:0];
`ifdef UDC_STICKY_FLAG_EN
    clr_flag = clr;
`endif
  endtask

  // Called at a falling edge: apply inputs, clock once, check, return at next falling edge.
  task automatic step(input bit e, input bit ud, input bit ld, input int lv,
                      input bit clr, input string tag);
    drive(e, ud, ld, lv, clr);
    model_edge(ld, lv, e, ud, clr);
    @(posedge clk);
    #2;
    check_all(tag);
    @(negedge clk);
  endtask

  // Async reset mid-cycle; inputs applied while reset is high must be ignored.
  task automatic async_reset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    drive(1'b1, $urandom_range(0, 1) == 1, 1'b1, int'($urandom_range(0, 15)), 1'b0);
    @(posedge clk);
    #2;
    check_all({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    m_max  = '{3, 5, 15};
    m_bits = '{2, 3, 4};
    m_rst  = '{0, 0, 3};
    m_sat  = '{1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Up count through the wrap boundary.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 0, 1'b0, "up");

    // Down count from 1 through the underflow boundary.
    step(1'b0, 1'b0, 1'b1, 1, 1'b0, "load1");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, "down");

    // Saturating climb from 0, then an over-range load that must clamp.
    step(1'b0, 1'b1, 1'b1, 0, 1'b0, "load0");
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 0, 1'b0, "sat_up");
    step(1'b0, 1'b1, 1'b1, 7, 1'b0, "clamp7");

    // Load beats enable on the same edge, then idle holds.
    step(1'b1, 1'b1, 1'b1, 9, 1'b0, "load_pri");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 0, 1'b0, "idle");

    // Asynchronous reset at q=6, then resume from RESET_VAL.
    step(1'b0, 1'b1, 1'b1, 6, 1'b0, "load6");
    async_reset("rst6");
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, "resume");

`ifdef UDC_STICKY_FLAG_EN
    // Sticky flag: set by a wrap, survives its drop, set beats clear, clear alone clears.
    step(1'b0, 1'b1, 1'b1, 3, 1'b0, "fl_load");
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, "fl_set");
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, "fl_keep");
    step(1'b0, 1'b1, 1'b1, 3, 1'b0, "fl_load2");
    step(1'b1, 1'b1, 1'b0, 0, 1'b1, "fl_setwins");
    step(1'b0, 1'b1, 1'b0, 0, 1'b1, "fl_clr");
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        async_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
             $urandom_range(0, 4) == 0, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
